// File: rtl/conv1x1_sched.sv
// rtl/conv1x1_sched.sv - pointwise convolution sequencer on one shared MAC, Q4.4 requantised output
// Define CONV1X1_SCHED_RELU_EN to clamp negative results to zero before writing.
module conv1x1_sched #(
  parameter int width = 8,
  parameter int frac  = 4,
  parameter int rows  = 3,
  parameter int cols  = 3,
  parameter int cin   = 4,
  parameter int cout  = 2
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                in_rd_en,
  output logic [$clog2(cin*rows*cols)-1:0]    in_addr,
  input  logic [width-1:0]                    in_data,
  output logic                                w_rd_en,
  output logic [$clog2(cin*cout)-1:0]         w_addr,
  input  logic [width-1:0]                    w_data,
  output logic                                out_we,
  output logic [$clog2(cout*rows*cols)-1:0]   out_addr,
  output logic [width-1:0]                    out_data
);

  localparam int NPIX  = rows * cols;
  localparam int IA_W  = $clog2(cin * NPIX);
  localparam int WA_W  = $clog2(cin * cout);
  localparam int OA_W  = $clog2(cout * NPIX);
  localparam int IC_W  = (cin > 1) ? $clog2(cin) : 1;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int OC_W  = (cout > 1) ? $clog2(cout) : 1;
  localparam int ACC_W = 2 * width + $clog2(cin) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-width+1){1'b1}}, {(width-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IC_W-1:0]         r_ic;
  logic [PIX_W-1:0]        r_pix;
  logic [OC_W-1:0]         r_oc;
  logic signed [ACC_W-1:0] r_acc;
  logic [IA_W-1:0]         r_in_addr;
  logic [WA_W-1:0]         r_w_addr;
  logic [OA_W-1:0]         r_out_addr;
  logic [width-1:0]        r_out_data;

  logic [IA_W-1:0]           w_in_lin;
  logic [WA_W-1:0]           w_w_lin;
  logic [OA_W-1:0]           w_out_lin;
  logic                      w_last_ic;
  logic                      w_last_pix;
  logic                      w_last_oc;
  logic signed [width-1:0]   w_in_s;
  logic signed [width-1:0]   w_wt_s;
  logic signed [2*width-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_shift;
  logic [width-1:0]          w_sat;
  logic [width-1:0]          w_result;

  assign w_in_lin  = IA_W'(r_ic) * IA_W'(NPIX) + IA_W'(r_pix);
  assign w_w_lin   = WA_W'(r_oc) * WA_W'(cin) + WA_W'(r_ic);
  assign w_out_lin = OA_W'(r_oc) * OA_W'(NPIX) + OA_W'(r_pix);

  assign w_last_ic  = (r_ic == IC_W'(cin - 1));
  assign w_last_pix = (r_pix == PIX_W'(NPIX - 1));
  assign w_last_oc  = (r_oc == OC_W'(cout - 1));

  // RAM data lands one cycle after the strobe, so the MAC always consumes last cycle's read.
  assign w_in_s     = in_data;
  assign w_wt_s     = w_data;
  assign w_prod     = w_in_s * w_wt_s;
  assign w_prod_ext = {{(ACC_W-2*width){w_prod[2*width-1]}}, w_prod};

  assign w_shift = r_acc >>> frac;

  always_comb begin
    if (w_shift > SAT_MAX) begin
      w_sat = {1'b0, {(width-1){1'b1}}};
    end else if (w_shift < SAT_MIN) begin
      w_sat = {1'b1, {(width-1){1'b0}}};
    end else begin
      w_sat = w_shift[width-1:0];
    end
  end

`ifdef CONV1X1_SCHED_RELU_EN
  assign w_result = w_sat[width-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Addresses and write data fall back to held registers so they stay stable between strobes.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    done     = 1'b0;
    in_rd_en = 1'b0;
    w_rd_en  = 1'b0;
    out_we   = 1'b0;
    in_addr  = r_in_addr;
    w_addr   = r_w_addr;
    out_addr = r_out_addr;
    out_data = r_out_data;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        in_rd_en = 1'b1;
        w_rd_en  = 1'b1;
        in_addr  = w_in_lin;
        w_addr   = w_w_lin;
        if (w_last_ic) begin
          w_next = S_LAST;
        end
      end
      S_LAST: begin
        w_next = S_WRITE;
      end
      S_WRITE: begin
        out_we   = 1'b1;
        out_addr = w_out_lin;
        out_data = w_result;
        w_next   = (w_last_pix && w_last_oc) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ic       <= '0;
      r_pix      <= '0;
      r_oc       <= '0;
      r_acc      <= '0;
      r_in_addr  <= '0;
      r_w_addr   <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ic  <= '0;
            r_pix <= '0;
            r_oc  <= '0;
            r_acc <= '0;
          end
        end
        S_FETCH: begin
          r_in_addr <= w_in_lin;
          r_w_addr  <= w_w_lin;
          // The product arriving at ic=0 belongs to nothing; the previous output took its last one in LAST.
          if (r_ic == '0) begin
            r_acc <= '0;
          end else begin
            r_acc <= r_acc + w_prod_ext;
          end
          r_ic <= w_last_ic ? '0 : r_ic + IC_W'(1);
        end
        S_LAST: begin
          r_acc <= r_acc + w_prod_ext;
        end
        S_WRITE: begin
          r_out_addr <= w_out_lin;
          r_out_data <= w_result;
          if (w_last_pix) begin
            r_pix <= '0;
            r_oc  <= w_last_oc ? '0 : r_oc + OC_W'(1);
          end else begin
            r_pix <= r_pix + PIX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
